// File: rtl/occupancy_tracker.sv
// Debounces the raw parked level into a stable occupancy state, emits arrive/depart
// pulses and keeps a saturating per-session dwell counter in seconds.
module occupancy_tracker #(
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int TICK_CYCLES     = 100000000,
    parameter int DWELL_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               parked,
    input  logic               clear_time,
    output logic               occupied,
    output logic               arrive,
    output logic               depart,
    output logic [DWELL_W-1:0] dwell_secs
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PRE_W = $clog2(TICK_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_ARRIVING = 2'd1;
    localparam logic [1:0] S_OCCUPIED = 2'd2;
    localparam logic [1:0] S_LEAVING  = 2'd3;

    logic               in_q;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               occupied_q, occupied_d;
    logic               arrive_q, arrive_d;
    logic               depart_q, depart_d;
    logic               in_session;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arrive_d = 1'b0;
        depart_d = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_q) begin
                    state_d = S_ARRIVING;
                    cnt_d   = '0;
                end
            end
            S_ARRIVING: begin
                if (!in_q) begin
                    state_d = S_EMPTY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_OCCUPIED;
                    cnt_d    = '0;
                    arrive_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OCCUPIED: begin
                if (!in_q) begin
                    state_d = S_LEAVING;
                    cnt_d   = '0;
                end
            end
            S_LEAVING: begin
                // A bounce back to occupied resumes the same session.
                if (in_q) begin
                    state_d = S_OCCUPIED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_EMPTY;
                    cnt_d    = '0;
                    depart_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_session = (state_q == S_OCCUPIED) || (state_q == S_LEAVING);
    assign occupied_d = (state_d == S_OCCUPIED) || (state_d == S_LEAVING);

    // Clear and a fresh arrival both restart the session clock; clear beats a tick.
    always_comb begin
        presc_d = presc_q;
        dwell_d = dwell_q;
        if (clear_time || arrive_d) begin
            presc_d = '0;
            dwell_d = '0;
        end else if (in_session) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                if (dwell_q != {DWELL_W{1'b1}}) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q       <= 1'b0;
            state_q    <= S_EMPTY;
            cnt_q      <= '0;
            presc_q    <= '0;
            dwell_q    <= '0;
            occupied_q <= 1'b0;
            arrive_q   <= 1'b0;
            depart_q   <= 1'b0;
        end else begin
            in_q       <= parked;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            dwell_q    <= dwell_d;
            occupied_q <= occupied_d;
            arrive_q   <= arrive_d;
            depart_q   <= depart_d;
        end
    end

    assign occupied   = occupied_q;
    assign arrive     = arrive_q;
    assign depart     = depart_q;
    assign dwell_secs = dwell_q;

endmodule

// File: doc/occupancy_tracker.md
Name: occupancy_tracker

Overview:
- Sits directly downstream of the joystick/proximity sensor stage and consumes its raw 1-bit `parked` level.
- Debounces `parked` into a stable occupancy state and emits one-cycle arrival/departure event pulses.
- Runs a per-session dwell-time counter in seconds, which the meter/billing logic reads.
- All logic is in the single system clock domain.

Parameters:
- DEBOUNCE_CYCLES, 5000000, consecutive cycles the input must hold a new level before state changes (50 ms at 100 MHz); minimum 1.
- TICK_CYCLES, 100000000, clk cycles per dwell-second tick; minimum 1.
- DWELL_W, 16, width of the dwell-seconds counter.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  synchronous, active-high reset
- parked  input  1  raw occupancy level from sensor stage; synchronous to clk
- clear_time  input  1  one-cycle strobe; zeroes dwell counter and tick prescaler
- occupied  output  1  debounced occupancy level
- arrive  output  1  one-cycle pulse on debounced EMPTY->occupied transition
- depart  output  1  one-cycle pulse on debounced occupied->EMPTY transition
- dwell_secs  output  DWELL_W  seconds elapsed in current/last session, saturating

Behaviour:
- Input stage: `parked` is registered once into in_q. The FSM acts on in_q only.
- Reset (rst=1 at a clk edge):
  - state=EMPTY.
  - in_q, debounce cnt, prescaler, dwell_secs all 0.
  - occupied, arrive, depart all 0.
  - Reset takes priority over every other input.
- States: EMPTY, ARRIVING, OCCUPIED, LEAVING. occupied=1 in OCCUPIED and LEAVING only. All outputs are registered.
- EMPTY:
  - in_q=1 -> ARRIVING, cnt=0.
  - Otherwise stay.
- ARRIVING:
  - in_q=0 -> EMPTY, cnt=0, no pulse.
  - in_q=1 and cnt==DEBOUNCE_CYCLES-1 -> OCCUPIED. On the same edge: arrive=1, dwell_secs=0, prescaler=0.
  - Else cnt+1.
- OCCUPIED:
  - in_q=0 -> LEAVING, cnt=0.
  - Dwell counting continues.
- LEAVING:
  - in_q=1 -> OCCUPIED, cnt=0, no pulse. The session continues and dwell is not reset.
  - in_q=0 and cnt==DEBOUNCE_CYCLES-1 -> EMPTY, depart=1.
  - Else cnt+1.
  - Dwell counting continues while in LEAVING.
- Latency:
  - `parked` changes before edge E0 and then holds -> arrive/depart and the occupied change appear after edge E0+DEBOUNCE_CYCLES+1.
  - A level change lasting <= DEBOUNCE_CYCLES cycles of in_q produces no state change and no pulse.
- arrive and depart are high for exactly one cycle. They never assert in the same cycle.
- Dwell timing:
  - The prescaler runs only in OCCUPIED/LEAVING.
  - When prescaler==TICK_CYCLES-1 it wraps to 0 and dwell_secs increments.
  - At all-ones, dwell_secs holds (saturates, no wrap).
- In EMPTY, dwell_secs is frozen at the last session value for meter readout. The next arrive zeroes it.
- clear_time=1:
  - dwell_secs=0 and prescaler=0 in any state.
  - Wins over a coincident tick.
  - Does not affect the FSM.
  - Coincident with arrive: result is dwell_secs=0, the same either way.
- Reset mid-session (any state): returns to EMPTY, occupied=0, no depart pulse emitted.
- cnt width is clog2(DEBOUNCE_CYCLES)+1. Prescaler width is clog2(TICK_CYCLES)+1.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=10, DWELL_W=4.
- Reset, then parked=1 from before edge E0 onward -> arrive=1 for exactly one cycle after edge E0+5; occupied=1 from E0+5; dwell_secs=0; depart stays 0.
- From EMPTY, parked=1 for 3 cycles then 0 -> occupied, arrive and depart stay 0 throughout; dwell_secs unchanged.
- After arrive, hold parked=1 for 35 cycles -> dwell_secs=3. Then parked=0 for 2 cycles, then 1 -> occupied stays 1, no depart, dwell_secs keeps counting (reaches 4 at 40 cycles after arrive).
- Occupied with dwell_secs=5, parked=0 held from before edge E0 -> depart pulse one cycle after E0+5; occupied=0; dwell_secs holds its final value in EMPTY for 100 cycles.
- Hold occupied for 200 cycles -> dwell_secs saturates at 15 and holds. Pulse clear_time on the same cycle as a tick -> dwell_secs=0, then increments to 1 ten cycles later.
- In LEAVING (cnt=2), assert rst for one cycle -> next cycle occupied=0, depart=0, dwell_secs=0. A new parked=1 gives arrive after 5 cycles.
